mem_responder: RTL and testbench

Memory-side responder for the multicycle CPU's memory port. It replaces the zero-latency data memory with a word-addressed RAM behind a req/ready/ack handshake. Each access costs a configurable number of wait states, so the CPU's FSM can be verified against a slow memory. It serves both instruction fetch and data load/store, which are not distinguished at this interface.

---
 rtl/mem_responder.sv | 104 ++++++++++
 tb/tb_mem_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed RAM behind a req/ready/ack handshake.
// Each access is held for a fixed number of wait states before a one-cycle ack.
module mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic                    lat_we;
  logic [31:0]             lat_addr, lat_wdata;
  logic                    acc_we;
  logic [31:0]             acc_addr, acc_wdata;
  logic                    acc_bad;
  logic                    enter_resp;
  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic [31:0]             mem [DEPTH];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    ack       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP: begin
        ack       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the acceptance edge itself,
  // so the access must use the live inputs rather than the latched copy.
  always_comb begin
    acc_addr   = (state == IDLE) ? addr  : lat_addr;
    acc_we     = (state == IDLE) ? we    : lat_we;
    acc_wdata  = (state == IDLE) ? wdata : lat_wdata;
    acc_bad    = (acc_addr[1:0] != 2'b00) || ((acc_addr[31:2] >> ADDR_WIDTH) != 30'd0);
    acc_idx    = acc_addr[ADDR_WIDTH+1:2];
    enter_resp = (state_nxt == RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req) begin
        lat_we    <= we;
        lat_addr  <= addr;
        lat_wdata <= wdata;
      end
      if (enter_resp) begin
        err   <= acc_bad;
        rdata <= (acc_bad || acc_we) ? '0 : mem[acc_idx];
      end
    end
  end

  // RAM contents survive reset; only the commit is gated by it.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && !acc_bad && acc_we)
      mem[acc_idx] <= acc_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: instance 0 uses 2 wait states, instance 1 uses none.
// Expected data comes from a per-instance array model of the RAM.
module tb_mem_responder;

  localparam int AW    = 10;
  localparam int DEPTH = 2**AW;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ready [2];
  logic        ack   [2];
  logic [31:0] rdata [2];
  logic        err   [2];

  logic [31:0] model [2][DEPTH];
  bit          vld   [2][DEPTH];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .ready(ready[0]), .ack(ack[0]), .rdata(rdata[0]), .err(err[0])
  );

  mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .ready(ready[1]), .ack(ack[1]), .rdata(rdata[1]), .err(err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= DEPTH);
  endfunction

  // One complete access on instance d; checks latency, response and idle-after-ack.
  task automatic access(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
    int          lat, lat_exp;
    bit          seen, bad, chk_r;
    logic [31:0] exp_r, held;
    int          idx;
    lat_exp = (d == 0) ? 3 : 1;
    bad     = is_bad(a);
    idx     = int'(a / 4) % DEPTH;
    chk_r   = 1'b1;
    exp_r   = '0;
    if (!bad && !w) begin
      if (vld[d][idx]) exp_r = model[d][idx];
      else             chk_r = 1'b0;
    end
    @(negedge clk);
    check($sformatf("ready_before_req%0d", d), ready[d], 1);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    @(posedge clk);
    if (!bad && w) begin
      model[d][idx] = wd;
      vld[d][idx]   = 1'b1;
    end
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // scramble inputs while busy; they must be ignored
        req[d] = 1'b0; we[d] = 1'($urandom); addr[d] = $urandom; wdata[d] = $urandom;
      end
      if (ack[d]) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    check($sformatf("latency%0d", d), lat, lat_exp);
    if (seen) begin
      check($sformatf("err%0d@%08h", d, a), err[d], bad);
      if (chk_r) check($sformatf("rdata%0d@%08h", d, a), rdata[d], exp_r);
      held = rdata[d];
      @(negedge clk);
      check($sformatf("ack_one_cycle%0d", d), ack[d], 0);
      check($sformatf("rdata_hold%0d", d), rdata[d], held);
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
    end
  endtask

  initial begin
    bit          seen;
    logic [31:0] a;
    int          d;
    idle_all();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_ready%0d", i), ready[i], 1);
      check($sformatf("rst_ack%0d", i), ack[i], 0);
      check($sformatf("rst_rdata%0d", i), rdata[i], 0);
      check($sformatf("rst_err%0d", i), err[i], 0);
    end

    // directed: write/read, misaligned, out of range
    access(0, 1'b1, 32'h10, 32'hDEADBEEF);
    access(0, 1'b0, 32'h10, 32'h0);
    access(0, 1'b0, 32'h13, 32'h0);
    check("misaligned_rdata", rdata[0], 0);
    access(0, 1'b0, 32'h10, 32'h0);
    access(0, 1'b1, 32'h0, 32'h0BADF00D);
    access(0, 1'b1, 32'h1000, 32'hFFFFFFFF);
    access(0, 1'b0, 32'h0, 32'h0);

    // zero wait states, req held: ack every second cycle, busy-cycle addr ignored
    for (int i = 0; i < 3; i++) access(1, 1'b1, 32'(i * 4), 32'hC0DE0000 + 32'(i));
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stream_ready_hi%0d", i), ready[1], 1);
      check($sformatf("stream_ack_lo%0d", i), ack[1], 0);
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'(i * 4);
      @(negedge clk);
      check($sformatf("stream_ack_hi%0d", i), ack[1], 1);
      check($sformatf("stream_ready_lo%0d", i), ready[1], 0);
      check($sformatf("stream_rdata%0d", i), rdata[1], model[1][i]);
      check($sformatf("stream_err%0d", i), err[1], 0);
      addr[1] = 32'h13; we[1] = 1'b1;
      @(negedge clk);
    end
    req[1] = 1'b0; we[1] = 1'b0;
    @(negedge clk);

    // reset during the wait phase drops the write and the ack
    access(0, 1'b1, 32'h20, 32'hA5A5A5A5);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h12345678;
    @(negedge clk);
    req[0] = 1'b0;
    rst_n  = 1'b0;
    seen   = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1) rst_n = 1'b1;
      if (ack[0]) seen = 1'b1;
    end
    check("rst_mid_no_ack", seen, 0);
    check("rst_mid_ready", ready[0], 1);
    access(0, 1'b0, 32'h20, 32'h0);

    // random mix on both instances
    for (int i = 0; i < 80; i++) begin
      d = int'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(1, 3));
        1:       a = 32'h1000 + 32'($urandom_range(0, 255) * 4);
        default: a = 32'($urandom_range(0, 15) * 4);
      endcase
      access(d, 1'($urandom), a, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
